booth_multiplier_8bit: RTL
==========================

BOOTH_MULTIPLIER_8BIT -- requirements
Module: booth_multiplier_8bit

Interface
REQ-001 SHALL have parameter: WIDTH, 8, operand width; 8 is the only supported value.
REQ-002 SHALL have port: clk  input  1  single clock; all state updates on its rising edge.
REQ-003 SHALL have port: rst  input  1  synchronous, active-high reset.
REQ-004 SHALL have port: start  input  1  request to begin a multiplication; sampled only in IDLE.
REQ-005 SHALL have port: multiplicand  input  8  signed two's-complement M; captured on accepted start.
REQ-006 SHALL have port: multiplier  input  8  signed two's-complement Q; captured on accepted start.
REQ-007 SHALL have port: busy  output  1  high while in CALC.
REQ-008 SHALL have port: done  output  1  one-cycle pulse; product valid.
REQ-009 SHALL have port: product  output  16  signed M*Q; registered; held until overwritten by the next completed result.

Function
REQ-010 SHALL implement FSM states IDLE, CALC, DONE.
REQ-011 IDLE: start=1 at a rising edge -> latch M, Q; A=0; Q_-1=0; iteration counter=0; next state CALC. start=0 -> remain IDLE.
REQ-012 CALC: one radix-2 Booth step per cycle, 8 cycles exactly.
REQ-013 Step: {Q[0],Q_-1}=01 -> A+M; 10 -> A-M, formed as A + ~M with Cin=1; 00/11 -> A unchanged, adder result ignored.
REQ-014 Step: after the add/sub, arithmetic right shift of {A,Q,Q_-1} by one bit.
REQ-015 Shift-in MSB = sum[7] XOR ovf, where ovf = (A[7]==B_eff[7]) AND (sum[7]!=A[7]), B_eff = operand presented to the adder; this makes M = -128 correct.
REQ-016 After the 8th step, product SHALL be loaded with {A,Q}; next state DONE.
REQ-017 DONE: done=1 for exactly one cycle; next state IDLE unconditionally.
REQ-018 Latency: start accepted at edge k -> done high during the cycle following edge k+9; busy high for the 8 cycles following edge k.
REQ-019 start in CALC or DONE SHALL be ignored and not queued; the next start is accepted only in IDLE.
REQ-020 Operand inputs SHALL be ignored except at the accepting edge; changes mid-operation do not affect the result.
REQ-021 Results SHALL be exact for all 65536 signed operand pairs; no overflow is possible in 16 bits.

Reset
REQ-022 rst=1 at a rising edge -> state IDLE; busy=0; done=0; product=16'h0000; A, Q, M, Q_-1 and counter cleared.
REQ-023 rst SHALL take priority over start, including start in the same cycle.
REQ-024 rst mid-CALC SHALL abort the operation without a done pulse; the partial result is not written to product.

Structure
REQ-025 Shared package alu_pkg SHALL hold the FSM state typedef (IDLE, CALC, DONE), WIDTH=8 and BOOTH_ITERS=8.
REQ-026 SHALL instantiate exactly one adder_8bit as sub-module: A = accumulator, B = M or ~M, Cin = subtract select; Cout unused.
REQ-027 Counter SHALL be 3 bits wide; wrap from 7 signals the last step.

Verification
REQ-028 M=8'h03, Q=8'h05, start pulse -> done exactly 9 cycles later; product=16'h000F.
REQ-029 M=8'hFD (-3), Q=8'h05 -> product=16'hFFF1 (-15); then M=8'h05, Q=8'hFD -> 16'hFFF1.
REQ-030 M=8'h80, Q=8'h80 -> product=16'h4000; M=8'h7F, Q=8'h80 -> product=16'hC080.
REQ-031 start held high continuously with M=8'h02, Q=8'h03 -> done pulses every 10 cycles; product=16'h0006; busy=0 in DONE and IDLE.
REQ-032 Start M=8'h10, Q=8'h10; assert rst in 4th CALC cycle -> no done pulse; product=16'h0000; busy=0 next cycle; a subsequent start computes 16'h0100 correctly.
REQ-033 Change operands and pulse start during CALC -> ignored; product equals the originally latched pair; exhaustive random sweep matches a signed reference model.

Source files
------------

// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : alu_pkg
// Description : Shared constants and FSM state type for the Booth multiplier.
// Revision    : 1.0 - initial release
// ============================================================================
package alu_pkg;

    localparam int WIDTH       = 8;
    localparam int BOOTH_ITERS = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage : alu_pkg
`default_nettype wire

// File: rtl/adder_8bit.sv
`default_nettype none
// ============================================================================
// Module      : adder_8bit
// Description : 8-bit ripple adder with carry-in and carry-out.
// Revision    : 1.0 - initial release
// ============================================================================
module adder_8bit (
    input  logic [7:0] i_a,
    input  logic [7:0] i_b,
    input  logic       i_cin,
    output logic [7:0] o_sum,
    output logic       o_cout
);

    logic [8:0] w_full;

    // Single wide add; the ninth bit is the carry out.
    always_comb begin
        w_full = {1'b0, i_a} + {1'b0, i_b} + {8'd0, i_cin};
        o_sum  = w_full[7:0];
        o_cout = w_full[8];
    end

endmodule : adder_8bit
`default_nettype wire

// File: rtl/booth_multiplier_8bit.sv
`default_nettype none
// ============================================================================
// Module      : booth_multiplier_8bit
// Description : Sequential radix-2 Booth signed multiplier, 8x8 -> 16 bits,
//               one Booth step per clock, IDLE/CALC/DONE control.
// Revision    : 1.0 - initial release
// ============================================================================
module booth_multiplier_8bit #(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [WIDTH-1:0]     multiplicand,
    input  logic [WIDTH-1:0]     multiplier,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   product
);

    import alu_pkg::state_t;
    import alu_pkg::IDLE;
    import alu_pkg::CALC;
    import alu_pkg::DONE;
    import alu_pkg::BOOTH_ITERS;

    localparam logic [2:0] C_LAST_STEP = 3'(BOOTH_ITERS - 1);

    state_t               r_state;
    logic [WIDTH-1:0]     r_a;
    logic [WIDTH-1:0]     r_q;
    logic [WIDTH-1:0]     r_m;
    logic                 r_q_m1;
    logic [2:0]           r_cnt;
    logic                 r_done;
    logic [2*WIDTH-1:0]   r_product;

    logic                 w_add_en;
    logic                 w_sub;
    logic [WIDTH-1:0]     w_b_eff;
    logic [WIDTH-1:0]     w_sum;
    logic                 w_unused_cout;
    logic                 w_ovf;
    logic [WIDTH-1:0]     w_a_pre;
    logic                 w_msb_in;
    logic [WIDTH-1:0]     w_a_next;
    logic [WIDTH-1:0]     w_q_next;

    // Booth recoding: 01 adds M, 10 subtracts M (as A + ~M + 1), else no-op.
    always_comb begin
        w_add_en = r_q[0] ^ r_q_m1;
        w_sub    = r_q[0] & ~r_q_m1;
        w_b_eff  = w_sub ? ~r_m : r_m;
    end

    adder_8bit u_adder (
        .i_a    (r_a),
        .i_b    (w_b_eff),
        .i_cin  (w_sub),
        .o_sum  (w_sum),
        .o_cout (w_unused_cout)
    );

    // Shift-in bit is the true 9-bit sign of the sum, recovered through the
    // overflow term, so that M = -128 (where A - M overflows 8 bits) is exact.
    always_comb begin
        w_ovf    = (r_a[WIDTH-1] == w_b_eff[WIDTH-1]) && (w_sum[WIDTH-1] != r_a[WIDTH-1]);
        w_a_pre  = w_add_en ? w_sum : r_a;
        w_msb_in = w_add_en ? (w_sum[WIDTH-1] ^ w_ovf) : r_a[WIDTH-1];
        w_a_next = {w_msb_in, w_a_pre[WIDTH-1:1]};
        w_q_next = {w_a_pre[0], r_q[WIDTH-1:1]};
    end

    // Control FSM and datapath registers; reset overrides any start request.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= IDLE;
            r_a       <= '0;
            r_q       <= '0;
            r_m       <= '0;
            r_q_m1    <= 1'b0;
            r_cnt     <= '0;
            r_done    <= 1'b0;
            r_product <= '0;
        end else begin
            // The done pulse follows the DONE state by one register stage.
            r_done <= (r_state == DONE);
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_m     <= multiplicand;
                        r_q     <= multiplier;
                        r_a     <= '0;
                        r_q_m1  <= 1'b0;
                        r_cnt   <= '0;
                        r_state <= CALC;
                    end
                end
                CALC: begin
                    r_a    <= w_a_next;
                    r_q    <= w_q_next;
                    r_q_m1 <= r_q[0];
                    r_cnt  <= r_cnt + 3'd1;
                    if (r_cnt == C_LAST_STEP) begin
                        r_product <= {w_a_next, w_q_next};
                        r_state   <= DONE;
                    end
                end
                DONE: begin
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    // Output mapping.
    always_comb begin
        busy    = (r_state == CALC);
        done    = r_done;
        product = r_product;
    end

endmodule : booth_multiplier_8bit
`default_nettype wire
